block_dispatcher: RTL and testbench
===================================

BLOCK_DISPATCHER -- requirements
Module: block_dispatcher

Interface
REQ-001 Parameter num_proc, default 2, number of processors served (1..8).
REQ-002 Parameter index_width, default 4, width of block row/column indices and of mu.
REQ-003 Parameter cell_width, default 8, width of the config word.
REQ-004 in_clk  input  1  single clock; all state changes on its rising edge.
REQ-005 in_reset  input  1  reset, asynchronous and active-high.
REQ-006 in_start  input  1  one-cycle start request for a full C computation.
REQ-007 in_mu  input  index_width  blocks per matrix dimension, sampled on accepted start.
REQ-008 in_config  input  cell_width  config word, sampled on accepted start.
REQ-009 in_index_ack  input  num_proc  per-processor acknowledge of offered indices.
REQ-010 in_result_ready  input  num_proc  per-processor one-cycle pulse: C block written to memory.
REQ-011 out_row_index  output  index_width  row index i of offered C_ij block (shared bus).
REQ-012 out_col_index  output  index_width  column index j of offered C_ij block (shared bus).
REQ-013 out_index_ready  output  num_proc  one-hot offer strobe; at most one bit high.
REQ-014 out_mu  output  index_width  latched mu, broadcast to all processors.
REQ-015 out_config  output  cell_width  latched config, broadcast to all processors.
REQ-016 out_busy  output  1  high from accepted start until done.
REQ-017 out_done  output  1  one-cycle pulse when every block is complete.

Function
REQ-018 FSM states: IDLE, SELECT, OFFER, DRAIN, DONE.
- IDLE: in_start=1 latches mu and config, sets i=j=0, goes to SELECT; if mu=0, goes straight to DONE.
REQ-019 Per-processor busy flags, all registered.
- SELECT: picks the lowest-numbered processor whose busy flag is clear and that is not completing this cycle.
- Processor found: drives its out_index_ready bit next cycle and enters OFFER.
- No processor free: stays in SELECT.
REQ-020 OFFER: out_index_ready bit, row and column held stable until that processor's in_index_ack is high.
- On ack: busy flag set, out_index_ready dropped the same edge, (i,j) advanced.
- Ack from a non-offered processor is ignored.
REQ-021 Index advance is row-major: j increments; when j=mu-1, j wraps to 0 and i increments.
- After (mu-1,mu-1) is acknowledged: go to DRAIN; otherwise return to SELECT.
REQ-022 A processor's in_result_ready pulse clears its busy flag at that edge.
- The processor is selectable from the following cycle.
- A pulse on a processor not marked busy is ignored.
REQ-023 DRAIN: waits until all busy flags are clear, then goes to DONE.
REQ-024 DONE: out_done=1 for exactly one cycle, then IDLE.
- out_busy is low in IDLE only.
REQ-025 in_start is ignored in every state except IDLE.
- in_mu and in_config changes after the start is accepted have no effect.
REQ-026 Completion counter: index_width*2+1 bits, increments per result pulse.
- DONE is reached only when counter equals mu*mu; a count mismatch in DRAIN with all flags clear holds DRAIN.
REQ-027 All outputs are registered; index offer latency from SELECT entry is 1 cycle.

Reset
REQ-028 Reset values: FSM=IDLE, busy flags=0, i=j=0, counter=0.
REQ-029 Reset output values: out_index_ready=0, out_row_index=0, out_col_index=0, out_mu=0, out_config=0, out_busy=0, out_done=0.
REQ-030 Reset asserted mid-operation aborts immediately with no done pulse; outstanding processors are not tracked after reset.

Structure
REQ-031 FSM state encodings and the index-advance width constants live in the shared coprocessor package.
REQ-032 One sub-module, proc_select: combinational lowest-free-index priority encoder over num_proc busy flags, returns one-hot grant and valid.
REQ-033 Counters, flags and FSM reside in block_dispatcher itself.

Verification
REQ-034 mu=2, num_proc=2, processors ack after 1 cycle and return result 5 cycles later.
- Offers in order (0,0)->P0, (0,1)->P1, (1,0), (1,1); out_done after 4th result; counter=4.
REQ-035 mu=0, in_start=1: out_done pulses 1 cycle later; no out_index_ready ever asserted.
REQ-036 Ack held off 3 cycles: out_index_ready bit and indices stay constant for the full 3 cycles, then drop on the ack edge.
REQ-037 Both processors busy; P1 result pulse and P0 result pulse on the same edge: next offer goes to P0.
- Following offer goes to P1; no dual offers.
REQ-038 mu=3, reset asserted after 4th ack: all outputs at reset values in the same cycle.
- Subsequent in_start with mu=1 completes normally with a single offer (0,0).
REQ-039 in_start pulsed while busy, with different in_mu: ignored; out_mu unchanged; done count matches the original mu.

Source files
------------

// File: rtl/block_dispatcher_pkg.sv
// Shared types and sizing constants for the matrix block dispatcher.
package block_dispatcher_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SELECT = 3'd1,
      ST_OFFER  = 3'd2,
      ST_DRAIN  = 3'd3,
      ST_DONE   = 3'd4
   } disp_state_t;

   // Completion counter must hold mu*mu plus one spare bit.
   localparam int CNT_WIDTH_MUL = 2;
   localparam int CNT_WIDTH_ADD = 1;

   function automatic int cnt_width(input int index_width);
      return index_width * CNT_WIDTH_MUL + CNT_WIDTH_ADD;
   endfunction

endpackage

// File: rtl/block_dispatcher_proc_select.sv
// Lowest-index-first grant over processors that are neither busy nor completing.
module block_dispatcher_proc_select #(
   parameter int num_proc = 2
) (
   input  logic [num_proc-1:0] in_blocked,
   output logic [num_proc-1:0] out_grant,
   output logic                out_valid
);

   always_comb begin
      out_grant = '0;
      for (int p = num_proc - 1; p >= 0; p--) begin
         if (!in_blocked[p]) begin
            out_grant    = '0;
            out_grant[p] = 1'b1;
         end
      end
      out_valid = |out_grant;
   end

endmodule

// File: rtl/block_dispatcher.sv
// Hands out C_ij block indices row-major to free processors and tracks
// result write-backs until every block of an mu x mu job is complete.
module block_dispatcher
   import block_dispatcher_pkg::*;
#(
   parameter int num_proc    = 2,
   parameter int index_width = 4,
   parameter int cell_width  = 8
) (
   input  logic                   in_clk,
   input  logic                   in_reset,
   input  logic                   in_start,
   input  logic [index_width-1:0] in_mu,
   input  logic [cell_width-1:0]  in_config,
   input  logic [num_proc-1:0]    in_index_ack,
   input  logic [num_proc-1:0]    in_result_ready,
   output logic [index_width-1:0] out_row_index,
   output logic [index_width-1:0] out_col_index,
   output logic [num_proc-1:0]    out_index_ready,
   output logic [index_width-1:0] out_mu,
   output logic [cell_width-1:0]  out_config,
   output logic                   out_busy,
   output logic                   out_done
);

   // state  | meaning
   // IDLE   | waiting for start; only state where start is honoured
   // SELECT | looking for the lowest free processor for block (i,j)
   // OFFER  | (i,j) offered to one processor, waiting for its ack
   // DRAIN  | all blocks handed out, waiting for outstanding results
   // DONE   | one-cycle completion, returns to IDLE

   localparam int cnt_w = cnt_width(index_width);

   disp_state_t            state_q, state_d;
   logic [index_width-1:0] mu_q, mu_d, row_q, row_d, col_q, col_d;
   logic [cell_width-1:0]  cfg_q, cfg_d;
   logic [num_proc-1:0]    busy_q, busy_d, offer_q, offer_d;
   logic [num_proc-1:0]    result_hit, grant;
   logic [cnt_w-1:0]       count_q, count_d, n_results, total_blocks;
   logic                   grant_valid, offer_ack, last_block;
   logic                   busy_out_q, busy_out_d, done_q, done_d;

   block_dispatcher_proc_select #(
      .num_proc (num_proc)
   ) u_proc_select (
      .in_blocked (busy_q | in_result_ready),
      .out_grant  (grant),
      .out_valid  (grant_valid)
   );

   assign result_hit   = in_result_ready & busy_q;
   assign offer_ack    = |(in_index_ack & offer_q);
   assign last_block   = (row_q == mu_q - index_width'(1)) && (col_q == mu_q - index_width'(1));
   assign total_blocks = cnt_w'(mu_q) * cnt_w'(mu_q);

   always_comb begin
      n_results = '0;
      for (int p = 0; p < num_proc; p++)
         n_results = n_results + cnt_w'(result_hit[p]);
   end

   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (in_start) state_d = (in_mu == '0) ? ST_DONE : ST_SELECT;
         ST_SELECT: if (grant_valid) state_d = ST_OFFER;
         ST_OFFER:  if (offer_ack) state_d = last_block ? ST_DRAIN : ST_SELECT;
         ST_DRAIN:  if (busy_q == '0 && count_q == total_blocks) state_d = ST_DONE;
         ST_DONE:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      mu_d    = mu_q;
      cfg_d   = cfg_q;
      row_d   = row_q;
      col_d   = col_q;
      offer_d = '0;
      busy_d  = busy_q & ~result_hit;
      count_d = count_q + n_results;
      unique case (state_q)
         ST_IDLE: begin
            if (in_start) begin
               mu_d    = in_mu;
               cfg_d   = in_config;
               row_d   = '0;
               col_d   = '0;
               count_d = '0;
            end
         end
         ST_SELECT: if (grant_valid) offer_d = grant;
         ST_OFFER: begin
            if (offer_ack) begin
               busy_d = busy_d | offer_q;
               if (col_q == mu_q - index_width'(1)) begin
                  col_d = '0;
                  row_d = row_q + index_width'(1);
               end else begin
                  col_d = col_q + index_width'(1);
               end
            end else begin
               offer_d = offer_q;
            end
         end
         default: ;
      endcase
      busy_out_d = (state_d != ST_IDLE);
      done_d     = (state_d == ST_DONE);
   end

   always_ff @(posedge in_clk or posedge in_reset) begin
      if (in_reset) begin
         mu_q       <= '0;
         cfg_q      <= '0;
         row_q      <= '0;
         col_q      <= '0;
         offer_q    <= '0;
         busy_q     <= '0;
         count_q    <= '0;
         busy_out_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         mu_q       <= mu_d;
         cfg_q      <= cfg_d;
         row_q      <= row_d;
         col_q      <= col_d;
         offer_q    <= offer_d;
         busy_q     <= busy_d;
         count_q    <= count_d;
         busy_out_q <= busy_out_d;
         done_q     <= done_d;
      end
   end

   assign out_row_index   = row_q;
   assign out_col_index   = col_q;
   assign out_index_ready = offer_q;
   assign out_mu          = mu_q;
   assign out_config      = cfg_q;
   assign out_busy        = busy_out_q;
   assign out_done        = done_q;

endmodule

// File: tb/tb_block_dispatcher.sv
// Self-checking bench: emulated processors with random ack/result timing
// against a row-major, lowest-free-processor reference model.
module tb_block_dispatcher;

   localparam int NP = 2;
   localparam int IW = 4;
   localparam int CW = 8;

   logic          in_clk = 1'b0;
   logic          in_reset = 1'b1;
   logic          in_start = 1'b0;
   logic [IW-1:0] in_mu = '0;
   logic [CW-1:0] in_config = '0;
   logic [NP-1:0] in_index_ack = '0;
   logic [NP-1:0] in_result_ready = '0;
   logic [IW-1:0] out_row_index, out_col_index, out_mu;
   logic [NP-1:0] out_index_ready;
   logic [CW-1:0] out_config;
   logic          out_busy, out_done;

   int n_checks = 0;
   int n_pass   = 0;
   int edge_cnt = 0;

   block_dispatcher #(
      .num_proc    (NP),
      .index_width (IW),
      .cell_width  (CW)
   ) dut (
      .in_clk          (in_clk),
      .in_reset        (in_reset),
      .in_start        (in_start),
      .in_mu           (in_mu),
      .in_config       (in_config),
      .in_index_ack    (in_index_ack),
      .in_result_ready (in_result_ready),
      .out_row_index   (out_row_index),
      .out_col_index   (out_col_index),
      .out_index_ready (out_index_ready),
      .out_mu          (out_mu),
      .out_config      (out_config),
      .out_busy        (out_busy),
      .out_done        (out_done)
   );

   always #5 in_clk = ~in_clk;
   always @(posedge in_clk) edge_cnt <= edge_cnt + 1;

   // One job with emulated processors. Inputs change and outputs are sampled
   // at the falling edge; edge_cnt names the rising edge just passed.
   task automatic run_job(input int mu, input int ack_lo, input int ack_hi,
                          input int res_lo, input int res_hi, input bit sync_res,
                          input int abort_acks, input bit poke_start, input bit noise);
      logic [CW-1:0] cfg;
      logic [IW-1:0] off_r, off_c;
      int total, next_blk, acks, results, pend, ack_cd, last_res, exp_p, got_p;
      int rcd[NP];
      bit hold[NP];
      int free_edge[NP];
      bit done_seen;
      total = mu * mu; next_blk = 0; acks = 0; results = 0; pend = -1;
      ack_cd = 0; last_res = -1; done_seen = 0; off_r = '0; off_c = '0;
      cfg = CW'($urandom);
      for (int p = 0; p < NP; p++) begin
         rcd[p] = 0; hold[p] = 0; free_edge[p] = 0;
      end
      @(negedge in_clk);
      in_start = 1'b1; in_mu = IW'(mu); in_config = cfg;
      @(negedge in_clk);
      in_start = 1'b0; in_mu = IW'($urandom); in_config = CW'($urandom);
      n_checks++;
      if (out_busy !== 1'b1 || out_mu !== IW'(mu) || out_config !== cfg)
         $display("FAIL start_latch busy=%b mu=%0d cfg=%h want busy=1 mu=%0d cfg=%h",
                  out_busy, out_mu, out_config, mu, cfg);
      else n_pass++;

      for (int cyc = 0; cyc < 3000 && !done_seen; cyc++) begin
         if (cyc > 0) @(negedge in_clk);
         for (int p = 0; p < NP; p++) begin
            if (in_result_ready[p]) begin
               in_result_ready[p] = 1'b0;
               hold[p] = 0; free_edge[p] = edge_cnt; results++;
               if (results == total) last_res = edge_cnt;
            end
         end
         if (pend >= 0 && in_index_ack[pend]) begin
            hold[pend] = 1; acks++;
            rcd[pend] = sync_res ? ((next_blk == 1) ? 6 : 4)
                                 : int'($urandom_range(res_hi, res_lo));
            n_checks++;
            if (out_index_ready !== '0)
               $display("FAIL ack_drop index_ready=%b want 0", out_index_ready);
            else n_pass++;
            pend = -1;
            if (abort_acks > 0 && acks == abort_acks) begin
               in_reset = 1'b1; in_index_ack = '0; in_result_ready = '0;
               #1;
               n_checks++;
               if ({out_index_ready, out_row_index, out_col_index, out_mu, out_config,
                    out_busy, out_done} !== '0)
                  $display("FAIL abort_reset rdy=%b row=%0d col=%0d mu=%0d cfg=%h busy=%b done=%b want all 0",
                           out_index_ready, out_row_index, out_col_index, out_mu, out_config,
                           out_busy, out_done);
               else n_pass++;
               @(negedge in_clk);
               in_reset = 1'b0;
               return;
            end
         end

         if (pend < 0) begin
            if (out_index_ready !== '0) begin
               exp_p = -1;
               for (int p = NP - 1; p >= 0; p--)
                  if (!hold[p] && free_edge[p] <= edge_cnt - 1) exp_p = p;
               got_p = -1;
               for (int p = NP - 1; p >= 0; p--)
                  if (out_index_ready[p]) got_p = p;
               n_checks++;
               if ($countones(out_index_ready) != 1 || got_p != exp_p)
                  $display("FAIL offer_proc index_ready=%b want P%0d", out_index_ready, exp_p);
               else n_pass++;
               n_checks++;
               if (next_blk >= total || out_row_index !== IW'(next_blk / mu)
                   || out_col_index !== IW'(next_blk % mu))
                  $display("FAIL offer_index got (%0d,%0d) want block %0d of %0d = (%0d,%0d)",
                           out_row_index, out_col_index, next_blk, total,
                           next_blk / mu, next_blk % mu);
               else n_pass++;
               off_r = out_row_index; off_c = out_col_index;
               pend = (got_p < 0) ? 0 : got_p;
               next_blk++;
               ack_cd = int'($urandom_range(ack_hi, ack_lo));
            end
         end else begin
            n_checks++;
            if (out_index_ready !== (NP'(1) << pend) || out_row_index !== off_r
                || out_col_index !== off_c)
               $display("FAIL offer_hold rdy=%b (%0d,%0d) want rdy=P%0d (%0d,%0d)",
                        out_index_ready, out_row_index, out_col_index, pend, off_r, off_c);
            else n_pass++;
         end

         in_index_ack = noise ? NP'($urandom) : '0;
         if (pend >= 0) begin
            in_index_ack[pend] = (ack_cd == 0);
            if (ack_cd > 0) ack_cd--;
         end
         for (int p = 0; p < NP; p++) begin
            if (hold[p]) begin
               if (rcd[p] == 0) in_result_ready[p] = 1'b1;
               else rcd[p]--;
            end
         end
         in_start = poke_start && (cyc == 3);
         if (in_start) in_mu = IW'(mu + 1);

         if (out_done === 1'b1) begin
            done_seen = 1;
            n_checks++;
            if (last_res < 0 || edge_cnt != last_res + 1 || next_blk != total)
               $display("FAIL done_timing edge=%0d want=%0d blocks=%0d want %0d",
                        edge_cnt, last_res + 1, next_blk, total);
            else n_pass++;
            n_checks++;
            if (out_busy !== 1'b1 || out_mu !== IW'(mu) || out_config !== cfg)
               $display("FAIL done_outputs busy=%b mu=%0d cfg=%h want busy=1 mu=%0d cfg=%h",
                        out_busy, out_mu, out_config, mu, cfg);
            else n_pass++;
         end
      end
      in_index_ack = '0; in_start = 1'b0;
      if (!done_seen) begin
         n_checks++;
         $display("FAIL done_timeout no done for mu=%0d, want done after %0d results", mu, total);
      end
      @(negedge in_clk);
      n_checks++;
      if (out_done !== 1'b0 || out_busy !== 1'b0)
         $display("FAIL done_pulse_len done=%b busy=%b want 0 0", out_done, out_busy);
      else n_pass++;
   endtask

   task automatic test_reset();
      in_reset = 1'b1;
      repeat (2) @(negedge in_clk);
      n_checks++;
      if ({out_index_ready, out_row_index, out_col_index, out_mu, out_config,
           out_busy, out_done} !== '0)
         $display("FAIL reset_outputs rdy=%b row=%0d col=%0d mu=%0d cfg=%h busy=%b done=%b want all 0",
                  out_index_ready, out_row_index, out_col_index, out_mu, out_config,
                  out_busy, out_done);
      else n_pass++;
      in_reset = 1'b0;
      repeat (2) @(negedge in_clk);
      n_checks++;
      if (out_busy !== 1'b0 || out_done !== 1'b0 || out_index_ready !== '0)
         $display("FAIL reset_idle busy=%b done=%b rdy=%b want 0 0 0",
                  out_busy, out_done, out_index_ready);
      else n_pass++;
   endtask

   task automatic test_basic_mu2();
      run_job(2, 1, 1, 5, 5, 0, 0, 0, 0);
   endtask

   task automatic test_mu_zero();
      @(negedge in_clk);
      in_start = 1'b1; in_mu = '0; in_config = 8'h5a;
      @(negedge in_clk);
      in_start = 1'b0;
      n_checks++;
      if (out_done !== 1'b1 || out_busy !== 1'b1 || out_index_ready !== '0)
         $display("FAIL mu0_done done=%b busy=%b rdy=%b want 1 1 0", out_done, out_busy, out_index_ready);
      else n_pass++;
      @(negedge in_clk);
      n_checks++;
      if (out_done !== 1'b0 || out_busy !== 1'b0 || out_index_ready !== '0 || out_config !== 8'h5a)
         $display("FAIL mu0_after done=%b busy=%b rdy=%b cfg=%h want 0 0 0 5a",
                  out_done, out_busy, out_index_ready, out_config);
      else n_pass++;
   endtask

   task automatic test_ack_holdoff();
      run_job(2, 3, 3, 2, 2, 0, 0, 0, 0);
   endtask

   task automatic test_simultaneous_results();
      run_job(2, 0, 0, 0, 0, 1, 0, 0, 0);
   endtask

   task automatic test_reset_abort();
      run_job(3, 0, 2, 1, 4, 0, 4, 0, 0);
      run_job(1, 0, 1, 1, 3, 0, 0, 0, 0);
   endtask

   task automatic test_start_ignored();
      run_job(2, 0, 2, 2, 6, 0, 0, 1, 0);
   endtask

   task automatic test_random();
      for (int k = 0; k < 8; k++)
         run_job(int'($urandom_range(4, 1)), 0, 3, 1, 8, 0, 0, 0, 1);
   endtask

   initial begin
      test_reset();
      test_basic_mu2();
      test_mu_zero();
      test_ack_holdoff();
      test_simultaneous_results();
      test_reset_abort();
      test_start_ignored();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
